// File: rtl/mont_const_gen.sv
// -----------------------------------------------------------------------------
// mont_const_gen
//   Precomputes the Montgomery domain constant C = 2^SHIFT mod N for the MME
//   exponentiator. One modular doubling is performed per clock: starting from
//   r = 1 (mod N), r is doubled SHIFT times with a conditional subtract of N.
//   done/err qualify C so the key-load path can gate MME's start1.
//
// Parameters
//   bits   MSB index of the operands; data width is bits+1
//   SHIFT  exponent of 2 (default 2*(bits+1), i.e. R^2 mod N with R = 2^(bits+1))
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; aborts a run with no done pulse
//   start1  request level, sampled only while idle
//   N       modulus, captured on the edge that accepts start1
//   C       result 2^SHIFT mod N, held until the next completion
//   done    one-cycle pulse marking C/err valid
//   busy    high from the accept edge until the completion edge
//   err     set when the last accepted N was 0; cleared on the next accept
//
// Handshake: start1 is a level request. It is taken on a rising edge while the
//   FSM is idle; from that edge busy is high and both start1 and N are ignored
//   until the completion edge, which raises done for exactly one cycle and
//   drops busy. done and busy are never high together.
// -----------------------------------------------------------------------------
module mont_const_gen #(
    parameter int bits  = 31,
    parameter int SHIFT = 2 * (bits + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start1,
    input  logic [bits:0] N,
    output logic [bits:0] C,
    output logic          done,
    output logic          busy,
    output logic          err
);

    localparam int W  = bits + 1;
    localparam int WR = bits + 2;
    localparam int CW = $clog2(SHIFT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Kept as a named enum register so checkers can bind to it directly.
    state_t          state;
    logic [WR-1:0]   r;
    logic [W-1:0]    n_q;
    logic [CW-1:0]   cnt;

    // r < n_q always holds, so r's top bit is zero and 2r fits in WR bits.
    logic [WR-1:0]   r_dbl;
    logic [WR-1:0]   n_ext;
    logic [WR-1:0]   r_next;

    always_comb begin
        r_dbl  = {r[WR-2:0], 1'b0};
        n_ext  = {1'b0, n_q};
        r_next = (r_dbl >= n_ext) ? (r_dbl - n_ext) : r_dbl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            r     <= '0;
            n_q   <= '0;
            cnt   <= '0;
            C     <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start1) begin
                        n_q  <= N;
                        err  <= 1'b0;
                        busy <= 1'b1;
                        cnt  <= '0;
                        if (N == '0) begin
                            state <= ST_DONE;
                        end else begin
                            // 1 mod N is 0 only for N == 1; that keeps r < n_q.
                            r     <= (N == W'(1)) ? '0 : WR'(1);
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r   <= r_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(SHIFT - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (n_q == '0) begin
                        C   <= '0;
                        err <= 1'b1;
                    end else begin
                        C   <= r[bits:0];
                        err <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_const_gen.sv
// -----------------------------------------------------------------------------
// tb_mont_const_gen
//   Directed bench for mont_const_gen with default parameters (32-bit, SHIFT=64).
//   Expected results are hand-computed constants; the random section uses a
//   reference computed with 64-bit arithmetic as ((2^64-1) mod N + 1) mod N.
// -----------------------------------------------------------------------------
module tb_mont_const_gen;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start1 = 1'b0;
    logic [W-1:0] N = '0;
    logic [W-1:0] C;
    logic         done;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;

    mont_const_gen dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start1 (start1),
        .N      (N),
        .C      (C),
        .done   (done),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_c(input logic [W-1:0] n);
        longint unsigned m;
        if (n == '0) return '0;
        m = 64'hFFFF_FFFF_FFFF_FFFF % {32'd0, n};
        return W'((m + 1) % {32'd0, n});
    endfunction

    // Drive a one-cycle start1 pulse; returns #1 after the accept edge.
    task automatic start_run(input logic [W-1:0] n);
        @(negedge clk);
        N      = n;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
    endtask

    // Called #1 after the accept edge. Counts edges until done is seen.
    task automatic wait_done(output bit seen, output int lat, output int busy_cnt,
                             output bit ovl);
        seen     = 1'b0;
        lat      = 0;
        ovl      = 1'b0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done && busy) ovl = 1'b1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    // Full run; after done, also samples the following cycle.
    task automatic do_run(input logic [W-1:0] n, output bit seen, output int lat,
                          output int busy_cnt, output bit ovl, output logic [W-1:0] c_out,
                          output logic err_out, output logic done_next);
        start_run(n);
        wait_done(seen, lat, busy_cnt, ovl);
        c_out   = C;
        err_out = err;
        @(posedge clk);
        #1;
        done_next = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({C, done, busy, err} !== {32'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_outputs: got C=%h done=%b busy=%b err=%b, need all zero",
                     C, done, busy, err);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: got done=%b busy=%b, need 0 0", done, busy);
        end
    endtask

    task automatic test_basic();
        bit seen, ovl;
        int lat, bc;
        logic [W-1:0] c;
        logic e, dn;
        do_run(32'd29, seen, lat, bc, ovl, c, e, dn);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL basic_timeout: done never seen within 200 edges");
        end
        checks++;
        if (lat !== 65) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges, need 65", lat);
        end
        checks++;
        if (bc !== 65) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, need 65", bc);
        end
        checks++;
        if (c !== 32'd24 || e !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got C=%0d err=%b, need C=24 err=0", c, e);
        end
        checks++;
        if (ovl !== 1'b0 || dn !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: got overlap=%b done_next=%b, need 0 0", ovl, dn);
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] n_tab [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
        logic [W-1:0] c_tab [3] = '{32'd1, 32'd0, 32'd0};
        bit seen, ovl;
        int lat, bc;
        logic [W-1:0] c;
        logic e, dn;
        for (int i = 0; i < 3; i++) begin
            do_run(n_tab[i], seen, lat, bc, ovl, c, e, dn);
            checks++;
            if (!seen || lat !== 65 || c !== c_tab[i] || e !== 1'b0) begin
                errors++;
                $display("FAIL boundary_%0d: N=%h got seen=%b lat=%0d C=%h err=%b, need lat=65 C=%h err=0",
                         i, n_tab[i], seen, lat, c, e, c_tab[i]);
            end
        end
    endtask

    task automatic test_zero_modulus();
        bit seen, ovl;
        int lat, bc;
        logic [W-1:0] c;
        logic e, dn;
        do_run(32'd0, seen, lat, bc, ovl, c, e, dn);
        checks++;
        if (!seen || lat !== 1 || bc !== 1) begin
            errors++;
            $display("FAIL zero_latency: got seen=%b lat=%0d busy=%0d, need lat=1 busy=1",
                     seen, lat, bc);
        end
        checks++;
        if (c !== 32'd0 || e !== 1'b1) begin
            errors++;
            $display("FAIL zero_result: got C=%h err=%b, need C=0 err=1", c, e);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL zero_err_sticky: got err=%b, need 1", err);
        end
        do_run(32'd29, seen, lat, bc, ovl, c, e, dn);
        checks++;
        if (c !== 32'd24 || e !== 1'b0) begin
            errors++;
            $display("FAIL zero_recover: got C=%0d err=%b, need C=24 err=0", c, e);
        end
    endtask

    task automatic test_ignore_busy();
        bit seen, ovl;
        int lat, bc;
        logic [W-1:0] c;
        logic e, dn;
        start_run(32'd29);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 9) begin
                N      = 32'd23;
                start1 = 1'b1;
            end
            if (k == 10) start1 = 1'b0;
        end
        wait_done(seen, lat, bc, ovl);
        checks++;
        if (!seen || (lat + 10) !== 65 || C !== 32'd24) begin
            errors++;
            $display("FAIL ignore_busy: got seen=%b lat=%0d C=%0d, need lat=65 C=24",
                     seen, lat + 10, C);
        end
        // 2^64 mod 23: the order of 2 mod 23 is 11, 64 = 5*11 + 9, 2^9 mod 23 = 6.
        do_run(32'd23, seen, lat, bc, ovl, c, e, dn);
        checks++;
        if (c !== 32'd6 || e !== 1'b0) begin
            errors++;
            $display("FAIL mod23: got C=%0d err=%b, need C=6 err=0", c, e);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen, ovl, saw_done;
        int lat, bc;
        logic [W-1:0] c;
        logic e, dn;
        start_run(32'd29);
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({C, done, busy, err} !== {32'd0, 3'b000}) begin
            errors++;
            $display("FAIL async_reset: got C=%h done=%b busy=%b err=%b, need all zero",
                     C, done, busy, err);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got activity after reset=%b, need 0", saw_done);
        end
        do_run(32'd29, seen, lat, bc, ovl, c, e, dn);
        checks++;
        if (!seen || c !== 32'd24) begin
            errors++;
            $display("FAIL reset_rerun: got seen=%b C=%0d, need C=24", seen, c);
        end
    endtask

    task automatic test_back_to_back();
        bit seen, ovl, c_bad, got;
        int lat, bc, gap;
        @(negedge clk);
        N      = 32'd29;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        wait_done(seen, lat, bc, ovl);
        checks++;
        if (!seen || lat !== 65 || C !== 32'd24) begin
            errors++;
            $display("FAIL b2b_first: got seen=%b lat=%0d C=%0d, need lat=65 C=24", seen, lat, C);
        end
        for (int p = 0; p < 2; p++) begin
            gap   = 0;
            c_bad = 1'b0;
            got   = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk);
                #1;
                gap++;
                if (C !== 32'd24) c_bad = 1'b1;
                if (done && busy) c_bad = 1'b1;
                if (done) begin
                    got = 1'b1;
                    break;
                end
            end
            if (p == 1) start1 = 1'b0;
            checks++;
            if (!got || gap !== 66 || c_bad) begin
                errors++;
                $display("FAIL b2b_period_%0d: got seen=%b gap=%0d c_glitch=%b, need gap=66 no glitch",
                         p, got, gap, c_bad);
            end
        end
        got = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) got = 1'b1;
        end
        checks++;
        if (got !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: got activity after start1 low=%b, need 0", got);
        end
    endtask

    task automatic test_random();
        bit seen, ovl;
        int lat, bc;
        logic [W-1:0] c, n, expv;
        logic e, dn;
        for (int i = 0; i < 6; i++) begin
            n = {$urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF)};
            n = W'(n | 32'd1);
            if (i == 0) n = 32'd3;
            expv = ref_c(n);
            do_run(n, seen, lat, bc, ovl, c, e, dn);
            checks++;
            if (!seen || c !== expv || e !== 1'b0) begin
                errors++;
                $display("FAIL random_%0d: N=%h got C=%h err=%b, need C=%h err=0",
                         i, n, c, e, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_zero_modulus();
        test_ignore_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
